// File: rtl/nic_pkg.sv
// Shared NIC definitions: register map, status bit, controller states.
// Imported by the access controller and its bus interface.
package nic_pkg;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  localparam int NIC_FULL_BIT = 0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_CAP   = 3'd2,
    POLL_REQ = 3'd3,
    POLL_CHK = 3'd4,
    WR       = 3'd5,
    DROP     = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/nic_access_ctrl_if.sv
// NIC register-file bus between the access controller and the NIC.
// master = controller side, slave = NIC side.
interface nic_access_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              nic_en;
  logic              nic_wr_en;
  logic [1:0]        nic_addr;
  logic [DATA_W-1:0] nic_din;
  logic [DATA_W-1:0] nic_dout;

  modport master (
    output nic_en,
    output nic_wr_en,
    output nic_addr,
    output nic_din,
    input  nic_dout
  );

  modport slave (
    input  nic_en,
    input  nic_wr_en,
    input  nic_addr,
    input  nic_din,
    output nic_dout
  );
endinterface

// File: rtl/nic_access_ctrl.sv
// Sequences one NIC access per instruction: timed loads with registered
// writeback, and output-buffer stores gated on output-status polling.
module nic_access_ctrl
  import nic_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MAX_POLL = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_addr,
  input  logic [4:0]        req_rd,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              store_err,
  nic_access_ctrl_if.master nic
);

  localparam int CNT_W =
    (MAX_POLL > 1) ? $clog2(MAX_POLL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_POLL - 1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [1:0]        addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          rd_d    = req_rd;
          wdata_d = req_wdata;
          if (!req_wr) begin
            state_d = RD_REQ;
          end else if (req_addr == NIC_OUT_BUF) begin
            state_d = POLL_REQ;
            cnt_d   = '0;
          end else begin
            state_d = WR;
          end
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = nic.nic_dout;
        state_d    = IDLE;
      end
      POLL_REQ: state_d = POLL_CHK;
      POLL_CHK: begin
        if (!nic.nic_dout[NIC_FULL_BIT]) begin
          state_d = WR;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DROP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = POLL_REQ;
        end
      end
      WR:      state_d = IDLE;
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NIC strobes are pure decodes of state and latched fields
  always_comb begin
    stall         = 1'b0;
    store_err     = 1'b0;
    nic.nic_en    = 1'b0;
    nic.nic_wr_en = 1'b0;
    nic.nic_addr  = 2'b00;
    nic.nic_din   = '0;
    unique case (state_q)
      IDLE: stall = req_valid;
      RD_REQ: begin
        stall        = 1'b1;
        nic.nic_en   = 1'b1;
        nic.nic_addr = addr_q;
      end
      POLL_REQ: begin
        stall        = 1'b1;
        nic.nic_en   = 1'b1;
        nic.nic_addr = NIC_OUT_STAT;
      end
      POLL_CHK: stall = 1'b1;
      WR: begin
        nic.nic_en    = 1'b1;
        nic.nic_wr_en = 1'b1;
        nic.nic_addr  = addr_q;
        nic.nic_din   = wdata_q;
      end
      DROP: store_err = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= 2'b00;
      rd_q       <= 5'd0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule
